// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive and transmit controllers
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned DEFAULT_BIT_CYCLES = 434;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_START   = 3'b001,
    ST_DATA    = 3'b010,
    ST_STOP    = 3'b011,
    ST_DONE    = 3'b100,
    ST_WAIT_HI = 3'b101
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period timer producing half-bit and full-bit ticks
module uart_bit_timer #(
  parameter int unsigned BIT_CYCLES  = 434,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic half_mode,
  output logic end_half_time,
  output logic end_bit_time
);

  localparam logic [15:0] BIT_TOP  = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] HALF_TOP = 16'(HALF_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        at_top;

  always_comb begin
    at_top = half_mode ? (cnt_q == HALF_TOP) : (cnt_q == BIT_TOP);
    cnt_d  = cnt_q + 16'd1;
    if (clr || at_top) begin
      cnt_d = 16'd0;
    end
    end_half_time = half_mode && at_top;
    end_bit_time  = !half_mode && at_top;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - 8N1 UART receiver with sticky valid, overrun and framing-error flags
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYCLES  = DEFAULT_BIT_CYCLES,
  parameter int unsigned HALF_CYCLES = BIT_CYCLES / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_i,
  input  logic                   rx_clr,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   rx_busy,
  output logic [2:0]             rx_state
);

  uart_state_e            state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shreg_q, shreg_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   over_q, over_d;
  logic                   ferr_q, ferr_d;
  logic                   tmr_clr;
  logic                   end_half;
  logic                   end_bit;
  logic                   start_edge;

  uart_bit_timer #(
    .BIT_CYCLES  (BIT_CYCLES),
    .HALF_CYCLES (HALF_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .clr           (tmr_clr),
    .half_mode     (state_q == ST_START),
    .end_half_time (end_half),
    .end_bit_time  (end_bit)
  );

  always_comb begin
    sync1_d    = rx_i;
    rx_s_d     = sync1_q;
    rx_prev_d  = rx_s_q;
    start_edge = !rx_s_q && rx_prev_q;

    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    over_d    = over_q;
    ferr_d    = ferr_q;
    tmr_clr   = 1'b0;

    // Clear first so that set events below take precedence in the same cycle.
    if (rx_clr) begin
      valid_d = 1'b0;
      over_d  = 1'b0;
      ferr_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (start_edge) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (end_half) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            tmr_clr   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (end_bit) begin
          shreg_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d   = ST_STOP;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (end_bit) begin
          if (rx_s_q) begin
            state_d = ST_DONE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_WAIT_HI;
          end
        end
      end
      ST_DONE: begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        if (valid_q && !rx_clr) begin
          over_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      // Holding here through a break keeps a long low line from looking like a new start.
      ST_WAIT_HI: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      bit_idx_q <= 3'd0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      over_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      over_q    <= over_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign overrun   = over_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != ST_IDLE);
  assign rx_state  = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl against a byte/flag reference model
module tb_uart_rx_ctrl;

  localparam int BITC  = 16;
  localparam int HALFC = 8;
  localparam int FRAME = 10 * BITC;

  logic       clk;
  logic       rst;
  logic       rx_i;
  logic       rx_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;
  logic [2:0] rx_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_over;
  logic       m_ferr;

  uart_rx_ctrl #(
    .BIT_CYCLES  (BITC),
    .HALF_CYCLES (HALFC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_clr    (rx_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx_busy   (rx_busy),
    .rx_state  (rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},  32'(rx_data),   32'(m_data));
    check({tag, "_valid"}, 32'(rx_valid),  32'(m_valid));
    check({tag, "_over"},  32'(overrun),   32'(m_over));
    check({tag, "_ferr"},  32'(frame_err), 32'(m_ferr));
  endtask

  // Line level for iteration c of a frame: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int c);
    int idx;
    idx = c / BITC;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return stop;
  endfunction

  task automatic model_good(input logic [7:0] b);
    m_over  = m_over | m_valid;
    m_valid = 1'b1;
    m_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    m_valid = 1'b0;
    m_over  = 1'b0;
    m_ferr  = 1'b0;
  endtask

  // Each iteration observes the DUT after the c-th clock edge since the start bit was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low,
                            input int clr_at, input int rst_at, output int rise_c);
    logic prev_valid;
    rise_c     = -1;
    prev_valid = rx_valid;
    for (int c = 0; c < FRAME + extra_low; c++) begin
      if (c == rst_at) return;
      if (rise_c < 0 && !prev_valid && rx_valid) rise_c = c;
      prev_valid = rx_valid;
      if (c == clr_at) check("done_state_at_clr", 32'(rx_state), 32'd4);
      rx_i   = (c < FRAME) ? frame_bit(b, stop, c) : 1'b0;
      rx_clr = (c == clr_at);
      @(negedge clk);
    end
    rx_clr = 1'b0;
  endtask

  initial begin
    int         rise;
    int         busy_cnt;
    logic [7:0] b;
    logic       stop;
    int         extra;

    rst    = 1'b1;
    rx_i   = 1'b1;
    rx_clr = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
    idle(3);
    check_model("reset");
    check("reset_busy",  32'(rx_busy),  32'd0);
    check("reset_state", 32'(rx_state), 32'd0);
    rst = 1'b0;
    idle(5);

    // Clean frame and end-to-end latency: 2 sync cycles + 152 to stop sample + DONE + register.
    send_frame(8'hA5, 1'b1, 0, -1, -1, rise);
    model_good(8'hA5);
    check("a5_latency", 32'(rise), 32'(2 + HALFC + 9 * BITC + 2));
    check_model("a5");
    check("a5_busy", 32'(rx_busy), 32'd0);
    idle(4);

    // Short glitch: START runs the half bit then aborts on a high sample.
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (rx_busy) busy_cnt++;
      rx_i = (c < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'(HALFC));
    check("glitch_state", 32'(rx_state), 32'd0);
    check_model("glitch");

    // Framing error with a held break.
    pulse_clr();
    send_frame(8'h3C, 1'b0, 40, -1, -1, rise);
    m_ferr = 1'b1;
    check("ferr_wait_hi", 32'(rx_state), 32'd5);
    check_model("ferr");
    rx_i = 1'b1;
    idle(4);
    check("ferr_idle", 32'(rx_state), 32'd0);
    check_model("ferr_after");

    // Back-to-back frames without clearing.
    pulse_clr();
    send_frame(8'h11, 1'b1, 0, -1, -1, rise);
    model_good(8'h11);
    send_frame(8'h22, 1'b1, 0, -1, -1, rise);
    model_good(8'h22);
    idle(2);
    check_model("b2b");
    pulse_clr();
    idle(1);
    check_model("b2b_clr");

    // Clear coinciding with DONE while a byte is already pending.
    send_frame(8'h96, 1'b1, 0, -1, -1, rise);
    model_good(8'h96);
    send_frame(8'h7E, 1'b1, 0, FRAME - 5, -1, rise);
    m_data = 8'h7E; m_valid = 1'b1; m_over = 1'b0; m_ferr = 1'b0;
    idle(2);
    check_model("clr_done");

    // Asynchronous reset in the middle of data bit 4.
    send_frame(8'hC3, 1'b1, 0, -1, 5 * BITC + BITC / 2, rise);
    rst  = 1'b1;
    rx_i = 1'b1;
    #1;
    m_data = 8'h00; m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
    check_model("midrst");
    check("midrst_busy",  32'(rx_busy),  32'd0);
    check("midrst_state", 32'(rx_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    send_frame(8'h5A, 1'b1, 0, -1, -1, rise);
    model_good(8'h5A);
    idle(2);
    check_model("post_rst");

    // Randomized frames with occasional framing errors and clears.
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) begin
        send_frame(b, 1'b1, 0, -1, -1, rise);
        model_good(b);
      end else begin
        extra = $urandom_range(0, 30);
        send_frame(b, 1'b0, extra, -1, -1, rise);
        m_ferr = 1'b1;
        rx_i   = 1'b1;
      end
      idle($urandom_range(3, 12));
      check_model("rand");
      check("rand_busy", 32'(rx_busy), 32'd0);
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        check_model("rand_clr");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receiver for the peripheral bus: it deserializes the 8N1 RS232 line into bytes. It is the receive-side counterpart of the UART transmitter controller.
- Synchronizes the asynchronous `rx_i` pin.
- Validates the start bit at mid-bit.
- Samples 8 data bits LSB-first, then checks the stop bit.
- Presents each byte with a sticky valid flag and error flags until software clears them.

## Interface
Parameters:
- `BIT_CYCLES`, 434, clock cycles per bit (50 MHz / 115200). Legal range 4..65535.
- `HALF_CYCLES`, `BIT_CYCLES/2`, cycles from detected start edge to the start-bit sample.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_i`  in  1  serial line, asynchronous to `clk`, idle high.
- `rx_clr`  in  1  one-cycle pulse; clears `rx_valid`, `overrun`, `frame_err`.
- `rx_data`  out  8  last correctly framed byte.
- `rx_valid`  out  1  sticky; set when a byte completes.
- `overrun`  out  1  sticky; a byte completed while `rx_valid` was already 1.
- `frame_err`  out  1  sticky; stop bit sampled low.
- `rx_busy`  out  1  high whenever the state is not IDLE.
- `rx_state`  out  3  current FSM state, for debug.

## Operation
- Synchronizer: 2 flops on `rx_i`, both reset to 1. `rx_s` is the second flop. A start edge is `rx_s`=0 while the previous `rx_s`=1.
- State encoding: IDLE=000, START=001, DATA=010, STOP=011, DONE=100, WAIT_HI=101. Unused encodings go to IDLE.
- IDLE: on a start edge, go to START and clear the bit timer.
- START: when the half tick fires, sample `rx_s`.
  - If 1, it is a false start: go to IDLE.
  - If 0, go to DATA with `bit_idx`=0 and restart the timer.
- DATA: on each full tick, shift `rx_s` into bit `bit_idx`, LSB first. After `bit_idx`=7, go to STOP.
- STOP: on the full tick, sample `rx_s`.
  - If 1, go to DONE.
  - If 0, set `frame_err`, leave `rx_data` unchanged, and go to WAIT_HI.
- DONE: lasts one cycle.
  - `rx_data` ← shift register.
  - If `rx_valid` is already 1 and `rx_clr` is 0, set `overrun`.
  - Set `rx_valid`. Go to IDLE.
- WAIT_HI: stay until `rx_s`=1, then go to IDLE. A break condition therefore cannot retrigger reception.
- `rx_clr` precedence:
  - Set events win over `rx_clr` in the same cycle.
  - When DONE coincides with `rx_clr`: `rx_valid`=1 and `overrun`=0.
  - When a framing-error set coincides with `rx_clr`: `frame_err`=1.
- Reset (any time, including mid-frame):
  - state IDLE; `rx_data`=0x00, `rx_valid`=0, `overrun`=0, `frame_err`=0, `rx_busy`=0.
  - Shift register 0, `bit_idx` 0, timer 0, synchronizer flops 1.

## Timing
- Cycle 0 is the cycle the start edge is detected on `rx_s`. Pin-to-`rx_s` delay is 2 cycles.
- Start sample occurs at cycle `HALF_CYCLES`.
- Data bit k (k = 0..7) is sampled at cycle `HALF_CYCLES + (k+1)*BIT_CYCLES`.
- Stop bit is sampled at cycle `HALF_CYCLES + 9*BIT_CYCLES`.
- DONE is the next cycle. `rx_valid` and `rx_data` are visible one cycle after DONE.
- Back-to-back frames are accepted: IDLE is reached half a bit before the stop bit ends, so the next start edge is caught.
- Timer counter width is 16 bits:
  - In START it counts 0..`HALF_CYCLES`-1 and fires the half tick at the top.
  - In DATA/STOP it counts 0..`BIT_CYCLES`-1, fires the full tick at the top, then wraps to 0.
- Outputs are all registered; no combinational path from `rx_i` or `rx_clr`.

## Structure
- Shared package `uart_pkg`: state encodings, `UART_DATA_W`=8, default `BIT_CYCLES`. The transmitter controller uses the same package.
- Sub-module `uart_bit_timer`:
  - Inputs: `clk`, `rst`, `clr`, `half_mode`.
  - Outputs: `end_half_time`, `end_bit_time` (one-cycle ticks).
  - The transmitter can reuse it.
- Top level holds the synchronizer, FSM, shift register, `bit_idx` counter and flag registers.

## Test plan
All scenarios use `BIT_CYCLES`=16 and `HALF_CYCLES`=8.
- Frame 0xA5 with stop bit 1 → `rx_data`=0xA5. `rx_valid` rises 154 cycles after `rx_s` falls (152 + DONE + register). `frame_err`=0, `overrun`=0.
- 3-cycle low glitch on `rx_i` → state returns to IDLE at start sample, `rx_valid` stays 0, `rx_busy` pulses about 8 cycles.
- 0x3C with stop bit 0, line held low 40 more cycles → `frame_err`=1, `rx_valid`=0, `rx_data` keeps prior value. FSM stays in WAIT_HI until line high, then IDLE.
- 0x11 then 0x22 back-to-back, no `rx_clr` → `rx_data`=0x22, `rx_valid`=1, `overrun`=1. A later `rx_clr` pulse clears all three flags.
- `rx_clr` asserted in the DONE cycle of 0x7E → `rx_valid`=1, `overrun`=0, `rx_data`=0x7E.
- `rst` asserted during data bit 4 → all outputs are reset values immediately. Next frame 0x5A is received correctly.
